pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 20 ++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Sequencer <-> ROM/datapath signal bundle. The sequencer drives the
// instruction pointer and status; the ROM/datapath side drives the rest.
interface pc_sequencer_if;
   logic [27:0] instruction;
   logic        branch_taken;
   logic        hold;
   logic [15:0] address;
   logic        stall;
   logic        stack_error;

   modport master (
      input  instruction, branch_taken, hold,
      output address, stall, stack_error
   );

   modport slave (
      output instruction, branch_taken, hold,
      input  address, stall, stack_error
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: JMP/BLE/CALL/RET flow control, NOP delay
// countdown, external freeze, and a bounded return-address stack.
module pc_sequencer #(
   parameter int         STACK_DEPTH = 8,
   parameter logic [3:0] OP_NOP      = 4'h0,
   parameter logic [3:0] OP_JMP      = 4'h1,
   parameter logic [3:0] OP_CALL     = 4'h2,
   parameter logic [3:0] OP_RET      = 4'h3,
   parameter logic [3:0] OP_BLE      = 4'h4
) (
   input logic            clk,
   input logic            rst,
   pc_sequencer_if.master bus
);
   localparam int SPW  = $clog2(STACK_DEPTH + 1);
   localparam int IDXW = $clog2(STACK_DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

   localparam logic [0:0] S_EXEC  = 1'b0;
   localparam logic [0:0] S_DELAY = 1'b1;

   logic [0:0]     state;
   logic [23:0]    cnt;
   logic [SPW-1:0] sp;
   logic [15:0]    addr;
   logic           err;
   logic [15:0]    stack [STACK_DEPTH];

   logic [3:0]     op;
   logic [15:0]    tgt;
   logic [15:0]    addr_inc;
   logic [23:0]    delay;
   logic [SPW-1:0] sp_dec;
   logic           adv;
   logic           full;
   logic           empty;
   logic           push;

   assign op       = bus.instruction[27:24];
   assign tgt      = {8'h00, bus.instruction[23:16]};
   assign delay    = bus.instruction[23:0];
   assign addr_inc = addr + 16'd1;
   assign sp_dec   = sp - SPW'(1);
   assign full     = (sp == SP_FULL);
   assign empty    = (sp == '0);
   assign adv      = !rst && !bus.hold && (state == S_EXEC);
   assign push     = adv && (op == OP_CALL) && !full;

   // Entries need no reset; sp alone defines which are live.
   always_ff @(posedge clk) begin
      if (push) stack[sp[IDXW-1:0]] <= addr_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr  <= '0;
         state <= S_EXEC;
         cnt   <= '0;
         sp    <= '0;
         err   <= 1'b0;
      end else if (!bus.hold) begin
         case (state)
            S_EXEC: begin
               case (op)
                  OP_NOP: begin
                     if (delay == '0) addr <= addr_inc;
                     else begin
                        cnt   <= delay;
                        state <= S_DELAY;
                     end
                  end
                  OP_JMP: addr <= tgt;
                  OP_BLE: addr <= bus.branch_taken ? tgt : addr_inc;
                  OP_CALL: begin
                     if (full) begin
                        err  <= 1'b1;
                        addr <= addr_inc;
                     end else begin
                        sp   <= sp + SPW'(1);
                        addr <= tgt;
                     end
                  end
                  OP_RET: begin
                     if (empty) begin
                        err  <= 1'b1;
                        addr <= addr_inc;
                     end else begin
                        sp   <= sp_dec;
                        addr <= stack[sp_dec[IDXW-1:0]];
                     end
                  end
                  default: addr <= addr_inc;
               endcase
            end
            S_DELAY: begin
               // Exit on 1 so that a NOP of N occupies N+1 cycles in total.
               if (cnt == 24'd1) begin
                  addr  <= addr_inc;
                  cnt   <= '0;
                  state <= S_EXEC;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            default: state <= S_EXEC;
         endcase
      end
   end

   assign bus.address     = addr;
   assign bus.stack_error = err;
   assign bus.stall       = bus.hold || ((state == S_DELAY) && !rst);
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed program scenarios plus a
// randomized program, checked against a queue-based reference model.
module tb_pc_sequencer;
   localparam int DEPTH = 2;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'h1;
   localparam logic [3:0] OP_CALL = 4'h2;
   localparam logic [3:0] OP_RET  = 4'h3;
   localparam logic [3:0] OP_BLE  = 4'h4;
   localparam logic [3:0] OP_SEQ  = 4'hF;

   typedef struct {
      logic [15:0] addr;
      logic        stall;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_sequencer_if ifc ();

   pc_sequencer #(
      .STACK_DEPTH(DEPTH),
      .OP_NOP(OP_NOP), .OP_JMP(OP_JMP), .OP_CALL(OP_CALL),
      .OP_RET(OP_RET), .OP_BLE(OP_BLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   logic [27:0] rom [0:65535];
   exp_t        q [$];
   int          checks   = 0;
   int          failures = 0;

   // Reference model: plain address, remaining-delay count, queue stack.
   logic [15:0] m_addr;
   int          m_wait;
   logic [15:0] m_stack [$];
   logic        m_err;
   logic        m_known = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [27:0] mk(input logic [3:0] op, input logic [23:0] f);
      return {op, f};
   endfunction

   task automatic model_step(input logic r, input logic h, input logic t);
      logic [27:0] w;
      logic [15:0] tg;
      if (r) begin
         m_addr = '0; m_wait = 0; m_stack.delete(); m_err = 1'b0; m_known = 1'b1;
      end else if (!h) begin
         if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_addr = m_addr + 16'd1;
         end else begin
            w  = rom[m_addr];
            tg = {8'h00, w[23:16]};
            case (w[27:24])
               OP_NOP:  if (w[23:0] == 24'd0) m_addr = m_addr + 16'd1;
                        else m_wait = int'(w[23:0]);
               OP_JMP:  m_addr = tg;
               OP_BLE:  m_addr = t ? tg : m_addr + 16'd1;
               OP_CALL: if (m_stack.size() == DEPTH) begin
                           m_err = 1'b1; m_addr = m_addr + 16'd1;
                        end else begin
                           m_stack.push_back(m_addr + 16'd1); m_addr = tg;
                        end
               OP_RET:  if (m_stack.size() == 0) begin
                           m_err = 1'b1; m_addr = m_addr + 16'd1;
                        end else m_addr = m_stack.pop_back();
               default: m_addr = m_addr + 16'd1;
            endcase
         end
      end
   endtask

   // One clock of stimulus: drive inputs, record what the DUT must show now.
   task automatic step(input logic r, input logic h, input logic t);
      @(negedge clk);
      rst = r;
      ifc.hold = h;
      ifc.branch_taken = t;
      ifc.instruction = rom[ifc.address];
      #1;
      if (m_known) q.push_back('{m_addr, h || (m_wait > 0 && !r), m_err});
      model_step(r, h, t);
   endtask

   task automatic run(input int n, input logic h, input logic t);
      for (int i = 0; i < n; i++) step(1'b0, h, t);
   endtask

   task automatic fill_seq();
      for (int i = 0; i < 65536; i++) rom[i] = mk(OP_SEQ, 24'h0);
   endtask

   function automatic logic [27:0] rand_word();
      int s;
      s = $urandom_range(0, 9);
      case (s)
         0, 1:    return mk(OP_NOP, {8'h00, 16'($urandom_range(0, 4))});
         2:       return mk(OP_JMP, {8'($urandom_range(0, 255)), 16'($urandom)});
         3:       return mk(OP_CALL, {8'($urandom_range(0, 255)), 16'($urandom)});
         4:       return mk(OP_RET, 24'($urandom));
         5, 6:    return mk(OP_BLE, {8'($urandom_range(0, 255)), 16'($urandom)});
         default: return mk(4'($urandom_range(5, 15)), 24'($urandom));
      endcase
   endfunction

   // Monitor: every cycle the DUT presents a PC; compare against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("address", 32'(ifc.address), 32'(e.addr));
            chk("stall", 32'(ifc.stall), 32'(e.stall));
            chk("stack_error", 32'(ifc.stack_error), 32'(e.err));
         end
      end
   end

   initial begin
      ifc.hold = 1'b0;
      ifc.branch_taken = 1'b0;
      ifc.instruction = '0;

      // Long NOP at address 0.
      fill_seq();
      rom[0] = mk(OP_NOP, 24'd4000);
      step(1'b1, 1'b0, 1'b0);
      run(4010, 1'b0, 1'b0);

      // Reset in the middle of a DELAY, hold asserted alongside.
      fill_seq();
      rom[0] = mk(OP_NOP, 24'd2000);
      step(1'b1, 1'b0, 1'b0);
      run(501, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      run(5, 1'b0, 1'b0);

      // CALL 17 at 5, RET at 20.
      fill_seq();
      rom[5]  = mk(OP_CALL, {8'd17, 16'h0});
      rom[20] = mk(OP_RET, 24'h0);
      step(1'b1, 1'b0, 1'b0);
      run(12, 1'b0, 1'b0);

      // BLE 17 at 19, taken then not taken.
      fill_seq();
      rom[19] = mk(OP_BLE, {8'd17, 16'h0});
      step(1'b1, 1'b0, 1'b0);
      run(22, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run(22, 1'b0, 1'b0);

      // Three nested calls on a two-deep stack, then RET on empty stack.
      fill_seq();
      rom[1]  = mk(OP_CALL, {8'd10, 16'h0});
      rom[10] = mk(OP_CALL, {8'd20, 16'h0});
      rom[20] = mk(OP_CALL, {8'd30, 16'h0});
      step(1'b1, 1'b0, 1'b0);
      run(30, 1'b0, 1'b0);
      rom[0] = mk(OP_RET, 24'h0);
      step(1'b1, 1'b0, 1'b0);
      run(3, 1'b0, 1'b0);

      // Hold during EXEC and during DELAY.
      fill_seq();
      rom[4] = mk(OP_NOP, 24'd10);
      step(1'b1, 1'b0, 1'b0);
      run(2, 1'b0, 1'b0);
      run(3, 1'b1, 1'b0);
      run(5, 1'b0, 1'b0);
      run(3, 1'b1, 1'b0);
      run(20, 1'b0, 1'b0);

      // Walk the full address space to see 16'hFFFF wrap to 0.
      fill_seq();
      step(1'b1, 1'b0, 1'b0);
      run(65540, 1'b0, 1'b0);

      // Random program with random hold, branch outcome and rare reset.
      for (int i = 0; i < 65536; i++) rom[i] = rand_word();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));

      @(negedge clk);
      #5;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
